// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_pkg
// Purpose  : Shared definitions for the countdown timer: controller state
//            encoding (IDLE = 0, RUN = 1), kept here so that other counter
//            blocks can reuse the same encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package countdown_timer_pkg;

  // Controller state: IDLE when no count is in flight, RUN otherwise.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : Loadable down-counter with enable, registered one-cycle
//            terminal-count pulse and one-shot / periodic (auto-reload) modes.
// Ports    : clk        - rising-edge clock
//            i_rst      - asynchronous active-high reset
//            i_sclr     - synchronous clear (same end state as reset)
//            i_en       - count enable, only honoured in RUN
//            i_load     - load strobe, samples i_load_val and i_periodic
//            i_load_val - start / reload value (unsigned, WIDTH bits)
//            i_periodic - 1 = auto-reload at terminal count, 0 = one-shot
//            o_cnt      - current count
//            o_tc       - terminal-count pulse (one cycle, registered)
//            o_busy     - high while the controller is in RUN
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_periodic,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ZERO = '0;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             periodic_q;
  logic             tc_q;
  state_e           state_q;

  // Priority: clear > load > count step > hold. The tc flag defaults low on
  // every edge and is only set on the terminal step, so it is a single-cycle
  // pulse unless a periodic reload of 1 keeps re-triggering it.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= c_ZERO;
      reload_q   <= c_ZERO;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
      state_q    <= ST_IDLE;
    end else if (i_sclr) begin
      cnt_q      <= c_ZERO;
      reload_q   <= c_ZERO;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
      state_q    <= ST_IDLE;
    end else if (i_load) begin
      // A load always restarts, discarding any count in flight, and wins
      // over a terminal count due on the same edge.
      cnt_q      <= i_load_val;
      reload_q   <= i_load_val;
      periodic_q <= i_periodic;
      tc_q       <= 1'b0;
      state_q    <= (i_load_val != c_ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (i_en) begin
            if (cnt_q == c_ONE) begin
              tc_q <= 1'b1;
              if (periodic_q) begin
                // RUN is only entered with a non-zero value, so reload is
                // never zero here.
                cnt_q <= reload_q;
              end else begin
                cnt_q   <= c_ZERO;
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - c_ONE;
            end
          end
        end
        default: begin
          // IDLE: enable ignored, count holds and never wraps.
        end
      endcase
    end
  end

  assign o_cnt  = cnt_q;
  assign o_tc   = tc_q;
  assign o_busy = (state_q == ST_RUN);

endmodule : countdown_timer
`default_nettype wire
